// File: rtl/clkctrl_divsel.sv
// ---------------------------------------------------------------------------
// clkctrl_divsel
//
// CPU clock source selector running entirely in the hsclk_in domain.
// clkout is either a registered divide-by-2*(div_sel+1) of hsclk_in (HS mode)
// or a registered, synchronised copy of lsclk_in (LS mode). Mode changes are
// glitch-free: HS is only left at the end of a high phase, and any mode is
// only (re)entered on a synchronised falling edge of lsclk_in.
//
// Parameters
//   DIV_W        width of div_sel
//   SYNC_STAGES  synchroniser depth on lsclk_in, must be >= 2
//
// Ports
//   hsclk_in        in   sole clock, rising edge
//   rst_b           in   asynchronous active-low reset
//   lsclk_in        in   slow reference clock, sampled as asynchronous data
//   hsclk_sel       in   1 = request HS mode, 0 = request LS mode
//   div_sel         in   HS half-period minus one, in hsclk_in cycles
//   clkout          out  CPU clock, registered
//   hsclk_selected  out  state is HS_RUN
//   lsclk_selected  out  state is LS_RUN
//   phase_end       out  one-cycle pulse in the cycle after clkout falls
//   rdy             out  CPU ready
//
// Build option
//   CLKSW_RDY_EN  when defined, rdy is a registered "requested mode is the
//                 active mode" flag; when undefined, rdy is tied to 1.
//
// Each LS half-period must be at least SYNC_STAGES+2 hsclk_in cycles long,
// otherwise the synchroniser can miss lsclk_in edges.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// LS_WAIT  | clkout held low, waiting for a synchronised lsclk_in fall
// LS_RUN   | clkout follows the synchronised lsclk_in
// HS_RUN   | clkout is the divided hsclk_in
// ---------------------------------------------------------------------------

module clkctrl_divsel #(
   parameter int DIV_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             hsclk_in,
   input  logic             rst_b,
   input  logic             lsclk_in,
   input  logic             hsclk_sel,
   input  logic [DIV_W-1:0] div_sel,
   output logic             clkout,
   output logic             hsclk_selected,
   output logic             lsclk_selected,
   output logic             phase_end,
   output logic             rdy
);

   typedef enum logic [1:0] {
      LS_WAIT = 2'd0,
      LS_RUN  = 2'd1,
      HS_RUN  = 2'd2
   } state_t;

   state_t                 state;
   logic [DIV_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] ls_sync;
   logic                   ls_s;
   logic                   ls_q;
   logic                   ls_fall;
   logic                   clkout_d;

   // -----------------------------------------------------------------------
   // lsclk_in synchroniser plus one history flop for fall detection
   // -----------------------------------------------------------------------
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         ls_sync <= '0;
         ls_q    <= 1'b0;
      end else begin
         ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_in};
         ls_q    <= ls_s;
      end
   end

   assign ls_s    = ls_sync[SYNC_STAGES-1];
   assign ls_fall = ls_q & ~ls_s;

   // -----------------------------------------------------------------------
   // Mode FSM with divider; status outputs registered with the state
   // -----------------------------------------------------------------------
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state          <= LS_WAIT;
         cnt            <= '0;
         clkout         <= 1'b0;
         hsclk_selected <= 1'b0;
         lsclk_selected <= 1'b0;
      end else begin
         case (state)
            LS_WAIT: begin
               clkout <= 1'b0;
               if (ls_fall) begin
                  // A request that flipped back to HS while waiting goes
                  // straight to HS_RUN without passing through LS_RUN.
                  if (hsclk_sel) begin
                     state          <= HS_RUN;
                     cnt            <= div_sel;
                     hsclk_selected <= 1'b1;
                     lsclk_selected <= 1'b0;
                  end else begin
                     state          <= LS_RUN;
                     hsclk_selected <= 1'b0;
                     lsclk_selected <= 1'b1;
                  end
               end
            end

            LS_RUN: begin
               if (ls_fall && hsclk_sel) begin
                  // ls_s has just fallen, so starting the HS low phase here
                  // extends the LS low level rather than cutting a high one.
                  state          <= HS_RUN;
                  cnt            <= div_sel;
                  clkout         <= 1'b0;
                  hsclk_selected <= 1'b1;
                  lsclk_selected <= 1'b0;
               end else begin
                  clkout <= ls_s;
               end
            end

            HS_RUN: begin
               if (cnt == '0) begin
                  if (clkout && !hsclk_sel) begin
                     // End of a complete high phase: safe point to leave HS.
                     clkout         <= 1'b0;
                     state          <= LS_WAIT;
                     hsclk_selected <= 1'b0;
                     lsclk_selected <= 1'b0;
                  end else begin
                     // div_sel is only sampled here and on entry, so a new
                     // value never stretches or cuts the running phase.
                     clkout <= ~clkout;
                     cnt    <= div_sel;
                  end
               end else begin
                  cnt <= cnt - DIV_W'(1);
               end
            end

            default: begin
               state          <= LS_WAIT;
               clkout         <= 1'b0;
               hsclk_selected <= 1'b0;
               lsclk_selected <= 1'b0;
            end
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Falling-edge pulse on clkout, one cycle after clkout goes low
   // -----------------------------------------------------------------------
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         clkout_d  <= 1'b0;
         phase_end <= 1'b0;
      end else begin
         clkout_d  <= clkout;
         phase_end <= clkout_d & ~clkout;
      end
   end

   // -----------------------------------------------------------------------
   // CPU ready
   // -----------------------------------------------------------------------
`ifdef CLKSW_RDY_EN
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         rdy <= 1'b0;
      end else begin
         rdy <= (hsclk_sel == hsclk_selected) && (state != LS_WAIT);
      end
   end
`else
   assign rdy = 1'b1;
`endif

endmodule

// File: tb/tb_clkctrl_divsel.sv
// ---------------------------------------------------------------------------
// Testbench for clkctrl_divsel (DIV_W=4, SYNC_STAGES=2, lsclk_in period of
// 16 hsclk_in cycles, 8 high / 8 low, driven synchronously at #1 after the
// hsclk_in rising edge).
// ---------------------------------------------------------------------------

module tb_clkctrl_divsel;

   localparam int DIV_W       = 4;
   localparam int SYNC_STAGES = 2;

`ifdef CLKSW_RDY_EN
   localparam logic RDY_RST = 1'b0;
`else
   localparam logic RDY_RST = 1'b1;
`endif

   logic             hsclk_in  = 1'b0;
   logic             rst_b     = 1'b0;
   logic             lsclk_in  = 1'b0;
   logic             hsclk_sel = 1'b0;
   logic [DIV_W-1:0] div_sel   = '0;
   logic             clkout;
   logic             hsclk_selected;
   logic             lsclk_selected;
   logic             phase_end;
   logic             rdy;

   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   int   ls_ctr = 0;
   logic ls_hist [0:8191];

   clkctrl_divsel #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .hsclk_in       (hsclk_in),
      .rst_b          (rst_b),
      .lsclk_in       (lsclk_in),
      .hsclk_sel      (hsclk_sel),
      .div_sel        (div_sel),
      .clkout         (clkout),
      .hsclk_selected (hsclk_selected),
      .lsclk_selected (lsclk_selected),
      .phase_end      (phase_end),
      .rdy            (rdy)
   );

   always #5 hsclk_in = ~hsclk_in;

   // One hsclk_in cycle: sample outputs of edge 'cyc', then drive lsclk_in
   // for the following edge. ls_hist[n] is lsclk_in as seen by edge n.
   task automatic tick();
      @(posedge hsclk_in);
      #1;
      cyc++;
      ls_ctr++;
      lsclk_in = ((ls_ctr % 16) < 8);
      ls_hist[cyc+1] = lsclk_in;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; hsclk_sel = 1'b0; div_sel = 4'd1;
      repeat (3) tick();
      checks++; if (clkout !== 1'b0) begin errors++; $display("FAIL reset_clkout got=%b exp=0", clkout); end
      checks++; if (hsclk_selected !== 1'b0) begin errors++; $display("FAIL reset_hs_sel got=%b exp=0", hsclk_selected); end
      checks++; if (lsclk_selected !== 1'b0) begin errors++; $display("FAIL reset_ls_sel got=%b exp=0", lsclk_selected); end
      checks++; if (phase_end !== 1'b0) begin errors++; $display("FAIL reset_phase_end got=%b exp=0", phase_end); end
      checks++; if (rdy !== RDY_RST) begin errors++; $display("FAIL reset_rdy got=%b exp=%b", rdy, RDY_RST); end
      rst_b  = 1'b1;
      ls_ctr = 0;
   endtask

   task automatic test_ls_startup();
      bit   found;
      logic exp_rdy;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (lsclk_selected === 1'b1) found = 1'b1;
         else begin
            checks++;
            if (clkout !== 1'b0) begin errors++; $display("FAIL ls_wait_clkout cyc=%0d got=%b exp=0", cyc, clkout); end
         end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL ls_entry_timeout got=no LS_RUN exp=LS_RUN within 40 cycles"); end
      checks++;
      if (!(ls_hist[cyc-2] === 1'b0 && ls_hist[cyc-3] === 1'b1)) begin
         errors++; $display("FAIL ls_entry_align cyc=%0d got=%b%b exp=10", cyc, ls_hist[cyc-3], ls_hist[cyc-2]);
      end
      for (int i = 0; i < 40; i++) begin
         checks++;
         if (clkout !== ls_hist[cyc-2]) begin errors++; $display("FAIL ls_track cyc=%0d got=%b exp=%b", cyc, clkout, ls_hist[cyc-2]); end
         checks++;
         if (lsclk_selected !== 1'b1 || hsclk_selected !== 1'b0) begin
            errors++; $display("FAIL ls_status cyc=%0d got=ls%b hs%b exp=ls1 hs0", cyc, lsclk_selected, hsclk_selected);
         end
         if (i >= 2) begin
            checks++;
            if (phase_end !== (ls_hist[cyc-4] & ~ls_hist[cyc-3])) begin
               errors++; $display("FAIL ls_phase_end cyc=%0d got=%b exp=%b", cyc, phase_end, ls_hist[cyc-4] & ~ls_hist[cyc-3]);
            end
         end
         exp_rdy = (i >= 1) ? 1'b1 : RDY_RST;
         checks++;
         if (rdy !== exp_rdy) begin errors++; $display("FAIL ls_rdy cyc=%0d got=%b exp=%b", cyc, rdy, exp_rdy); end
         tick();
      end
   endtask

   task automatic test_hs_entry();
      int   n;
      logic exp_clk;
      logic exp_pe;
      logic exp_rdy;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL hs_pre_rdy got=%b exp=1", rdy); end
      hsclk_sel = 1'b1; div_sel = 4'd1;
      tick();
      checks++; if (rdy !== RDY_RST) begin errors++; $display("FAIL hs_req_rdy got=%b exp=%b", rdy, RDY_RST); end
      n = 0;
      while (hsclk_selected !== 1'b1 && n < 40) begin
         checks++;
         if (lsclk_selected !== 1'b1) begin errors++; $display("FAIL hs_wait_ls_sel cyc=%0d got=%b exp=1", cyc, lsclk_selected); end
         tick(); n++;
      end
      checks++;
      if (hsclk_selected !== 1'b1) begin errors++; $display("FAIL hs_entry_timeout got=%b exp=1", hsclk_selected); end
      checks++;
      if (!(ls_hist[cyc-2] === 1'b0 && ls_hist[cyc-3] === 1'b1)) begin
         errors++; $display("FAIL hs_entry_align cyc=%0d got=%b%b exp=10", cyc, ls_hist[cyc-3], ls_hist[cyc-2]);
      end
      for (int j = 0; j < 16; j++) begin
         exp_clk = ((j / 2) % 2) != 0;
         exp_pe  = (j % 4) == 1;
         exp_rdy = (j == 0) ? RDY_RST : 1'b1;
         checks++; if (clkout !== exp_clk) begin errors++; $display("FAIL hs_div1_clkout j=%0d got=%b exp=%b", j, clkout, exp_clk); end
         checks++; if (phase_end !== exp_pe) begin errors++; $display("FAIL hs_div1_phase_end j=%0d got=%b exp=%b", j, phase_end, exp_pe); end
         checks++;
         if (hsclk_selected !== 1'b1 || lsclk_selected !== 1'b0) begin
            errors++; $display("FAIL hs_status j=%0d got=hs%b ls%b exp=hs1 ls0", j, hsclk_selected, lsclk_selected);
         end
         checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL hs_rdy j=%0d got=%b exp=%b", j, rdy, exp_rdy); end
         if (j < 15) tick();
      end
   endtask

   task automatic test_div_change();
      bit   found;
      logic prev;
      logic exp_clk;
      found = 1'b0; prev = clkout;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (clkout === 1'b1 && prev === 1'b0) found = 1'b1;
         prev = clkout;
      end
      checks++; if (!found) begin errors++; $display("FAIL div_change_rise_timeout got=none exp=rising clkout"); end
      div_sel = 4'd3;
      for (int j = 1; j <= 17; j++) begin
         tick();
         exp_clk = (j < 2) ? 1'b1 : ((((j - 2) / 4) % 2) != 0);
         checks++; if (clkout !== exp_clk) begin errors++; $display("FAIL div_change_clkout j=%0d got=%b exp=%b", j, clkout, exp_clk); end
      end
   endtask

   task automatic test_hs_exit();
      bit   found;
      logic prev;
      logic exp_clk;
      logic exp_hs;
      logic last;
      int   run;
      int   n;
      found = 1'b0; prev = clkout;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (clkout === 1'b0 && prev === 1'b1) found = 1'b1;
         prev = clkout;
      end
      checks++; if (!found) begin errors++; $display("FAIL hs_exit_fall_timeout got=none exp=falling clkout"); end
      tick();
      hsclk_sel = 1'b0;
      last = 1'b0; run = 2;
      for (int j = 2; j <= 8; j++) begin
         tick();
         exp_clk = (j >= 4 && j < 8);
         exp_hs  = (j < 8);
         checks++; if (clkout !== exp_clk) begin errors++; $display("FAIL hs_exit_clkout j=%0d got=%b exp=%b", j, clkout, exp_clk); end
         checks++; if (hsclk_selected !== exp_hs) begin errors++; $display("FAIL hs_exit_hs_sel j=%0d got=%b exp=%b", j, hsclk_selected, exp_hs); end
         if (j == 2) begin
            checks++; if (rdy !== RDY_RST) begin errors++; $display("FAIL hs_exit_rdy got=%b exp=%b", rdy, RDY_RST); end
         end
         if (clkout === last) run++;
         else begin
            checks++; if (run < 4) begin errors++; $display("FAIL hs_exit_short_phase cyc=%0d got=%0d exp>=4", cyc, run); end
            run = 1; last = clkout;
         end
      end
      n = 0;
      while (lsclk_selected !== 1'b1 && n < 40) begin
         tick(); n++;
         if (lsclk_selected !== 1'b1) begin
            checks++; if (clkout !== 1'b0) begin errors++; $display("FAIL hs_exit_hold_clkout cyc=%0d got=%b exp=0", cyc, clkout); end
         end
         if (clkout === last) run++;
         else begin
            checks++; if (run < 4) begin errors++; $display("FAIL hs_exit_short_phase cyc=%0d got=%0d exp>=4", cyc, run); end
            run = 1; last = clkout;
         end
      end
      checks++; if (lsclk_selected !== 1'b1) begin errors++; $display("FAIL hs_exit_ls_timeout got=%b exp=1", lsclk_selected); end
      for (int i = 0; i < 24; i++) begin
         tick();
         checks++; if (clkout !== ls_hist[cyc-2]) begin errors++; $display("FAIL hs_exit_ls_track cyc=%0d got=%b exp=%b", cyc, clkout, ls_hist[cyc-2]); end
         if (clkout === last) run++;
         else begin
            checks++; if (run < 4) begin errors++; $display("FAIL hs_exit_short_phase cyc=%0d got=%0d exp>=4", cyc, run); end
            run = 1; last = clkout;
         end
      end
   endtask

   task automatic test_reversal();
      int n;
      div_sel = 4'd1; hsclk_sel = 1'b1;
      n = 0;
      while (hsclk_selected !== 1'b1 && n < 40) begin tick(); n++; end
      checks++; if (hsclk_selected !== 1'b1) begin errors++; $display("FAIL rev_hs_timeout got=%b exp=1", hsclk_selected); end
      hsclk_sel = 1'b0;
      n = 0;
      while (hsclk_selected !== 1'b0 && n < 12) begin
         tick(); n++;
         checks++; if (lsclk_selected !== 1'b0) begin errors++; $display("FAIL rev_exit_ls_sel cyc=%0d got=%b exp=0", cyc, lsclk_selected); end
      end
      checks++; if (hsclk_selected !== 1'b0) begin errors++; $display("FAIL rev_exit_timeout got=%b exp=0", hsclk_selected); end
      hsclk_sel = 1'b1;
      n = 0;
      while (hsclk_selected !== 1'b1 && n < 40) begin
         tick(); n++;
         checks++; if (lsclk_selected !== 1'b0) begin errors++; $display("FAIL rev_ls_sel cyc=%0d got=%b exp=0", cyc, lsclk_selected); end
         checks++; if (clkout !== 1'b0) begin errors++; $display("FAIL rev_hold_clkout cyc=%0d got=%b exp=0", cyc, clkout); end
      end
      checks++; if (hsclk_selected !== 1'b1) begin errors++; $display("FAIL rev_reentry_timeout got=%b exp=1", hsclk_selected); end
      checks++;
      if (!(ls_hist[cyc-2] === 1'b0 && ls_hist[cyc-3] === 1'b1)) begin
         errors++; $display("FAIL rev_entry_align cyc=%0d got=%b%b exp=10", cyc, ls_hist[cyc-3], ls_hist[cyc-2]);
      end
   endtask

   task automatic test_div_extremes();
      bit   found;
      logic prev;
      logic exp_clk;
      logic exp_pe;
      found = 1'b0; prev = clkout;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (clkout === 1'b1 && prev === 1'b0) found = 1'b1;
         prev = clkout;
      end
      checks++; if (!found) begin errors++; $display("FAIL div0_rise_timeout got=none exp=rising clkout"); end
      div_sel = 4'd0;
      for (int j = 1; j <= 8; j++) begin
         tick();
         exp_clk = (j < 2) ? 1'b1 : (((j - 2) % 2) != 0);
         checks++; if (clkout !== exp_clk) begin errors++; $display("FAIL div0_clkout j=%0d got=%b exp=%b", j, clkout, exp_clk); end
      end
      found = 1'b0; prev = clkout;
      for (int i = 0; i < 6 && !found; i++) begin
         tick();
         if (clkout === 1'b1 && prev === 1'b0) found = 1'b1;
         prev = clkout;
      end
      checks++; if (!found) begin errors++; $display("FAIL div15_rise_timeout got=none exp=rising clkout"); end
      div_sel = 4'd15;
      for (int j = 1; j <= 33; j++) begin
         tick();
         exp_clk = (j >= 17 && j <= 32);
         exp_pe  = (j == 2);
         checks++; if (clkout !== exp_clk) begin errors++; $display("FAIL div15_clkout j=%0d got=%b exp=%b", j, clkout, exp_clk); end
         checks++; if (phase_end !== exp_pe) begin errors++; $display("FAIL div15_phase_end j=%0d got=%b exp=%b", j, phase_end, exp_pe); end
      end
   endtask

   task automatic test_async_reset();
      bit   found;
      logic prev;
      found = 1'b0; prev = clkout;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (clkout === 1'b1 && prev === 1'b0) found = 1'b1;
         prev = clkout;
      end
      checks++; if (!found) begin errors++; $display("FAIL areset_rise_timeout got=none exp=rising clkout"); end
      #2;
      rst_b = 1'b0;
      #1;
      checks++; if (clkout !== 1'b0) begin errors++; $display("FAIL areset_clkout got=%b exp=0", clkout); end
      checks++; if (hsclk_selected !== 1'b0) begin errors++; $display("FAIL areset_hs_sel got=%b exp=0", hsclk_selected); end
      checks++; if (phase_end !== 1'b0) begin errors++; $display("FAIL areset_phase_end got=%b exp=0", phase_end); end
      checks++; if (rdy !== RDY_RST) begin errors++; $display("FAIL areset_rdy got=%b exp=%b", rdy, RDY_RST); end
      tick();
      checks++; if (clkout !== 1'b0) begin errors++; $display("FAIL areset_hold_clkout got=%b exp=0", clkout); end
   endtask

   initial begin
      ls_hist[0] = 1'b0;
      ls_hist[1] = 1'b0;
      test_reset();
      test_ls_startup();
      test_hs_entry();
      test_div_change();
      test_hs_exit();
      test_reversal();
      test_div_extremes();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clkctrl_divsel.md
# clkctrl_divsel

Parametrised successor to the PHI2 clock switch. It runs entirely in the `hsclk_in` domain and builds the CPU clock from that clock. The output is either a registered divide-by-2×(N+1) of `hsclk_in` or a registered, synchronised copy of `lsclk_in`. Switching between the two is glitch-free and happens only at the end of a high (PHI2) phase. The block sits between the board clock inputs and the CPU `PHI0`, with `hsclk_sel`/`div_sel` driven by the speed-control register logic.

## Interface
- `DIV_W`, 4: width of `div_sel`.
- `SYNC_STAGES`, 2: synchroniser flops on `lsclk_in`; must be ≥ 2.
- `hsclk_in  in  1`: sole clock, rising-edge.
- `rst_b  in  1`: reset, asynchronous, active-low.
- `lsclk_in  in  1`: slow reference clock, treated as asynchronous data.
- `hsclk_sel  in  1`: 1 requests HS mode, 0 requests LS mode; synchronous to `hsclk_in`.
- `div_sel  in  DIV_W`: HS half-period minus one, in `hsclk_in` cycles.
- `clkout  out  1`: CPU clock, registered.
- `hsclk_selected  out  1`: state is HS_RUN.
- `lsclk_selected  out  1`: state is LS_RUN.
- `phase_end  out  1`: one-cycle pulse, registered, asserted in the cycle after `clkout` falls 1→0.
- `rdy  out  1`: CPU ready (see Configuration).

## Operation
- **Synchroniser.** `lsclk_in` passes through `SYNC_STAGES` flops to give `ls_s`, plus one history flop `ls_q`. `ls_fall` = `ls_q & !ls_s`.
- **State machine.** States are LS_WAIT (reset state), LS_RUN and HS_RUN.
- **LS_WAIT**
  - `clkout` is held at 0.
  - On `ls_fall`: go to HS_RUN if `hsclk_sel`=1, else LS_RUN.
- **LS_RUN**
  - `clkout` <= `ls_s`.
  - On `ls_fall` with `hsclk_sel`=1: go to HS_RUN.
- **Entering HS_RUN**
  - `cnt` <= `div_sel`, `clkout` <= 0.
- **HS_RUN**
  - `cnt` decrements each cycle.
  - When `cnt`=0: toggle `clkout` and reload `cnt` <= `div_sel`.
  - `div_sel` is sampled only at entry and at each reload. A change therefore takes effect from the next phase; the current phase is never stretched or cut.
- **Leaving HS_RUN**
  - Checked at `cnt`=0 with `clkout`=1 (end of a high phase) and `hsclk_sel`=0.
  - Action: `clkout` <= 0, go to LS_WAIT.
  - `hsclk_sel` is ignored at all other points in HS_RUN.
- **Request reversal during LS_WAIT.** If `hsclk_sel` returns to 1 while in LS_WAIT, the next `ls_fall` goes directly to HS_RUN. LS_RUN is not entered.
- **Status outputs.**
  - `hsclk_selected` = state==HS_RUN.
  - `lsclk_selected` = state==LS_RUN.
  - Both are registered alongside the state.
- **Reset values** (asynchronous, all outputs):
  - `clkout`=0, `hsclk_selected`=0, `lsclk_selected`=0, `phase_end`=0.
  - `rdy`=0 if `CLKSW_RDY_EN` is defined, else 1.
  - `cnt`=0; synchroniser and history flops = 0.
- **Reset mid-phase.** `clkout` drops to 0 immediately; the truncated phase is acceptable because the CPU is also in reset.

## Timing
- LS path latency: a `clkout` edge follows the corresponding `lsclk_in` edge by `SYNC_STAGES`+1 `hsclk_in` cycles (±1 for sampling).
- HS mode: each `clkout` level lasts exactly `div_sel`+1 cycles.
  - `div_sel`=0 gives `hsclk_in`/2.
  - Maximum divide is 2×2^DIV_W.
- HS entry: the `clkout` low phase starts on the cycle `ls_fall` is seen and lasts `div_sel`+1 cycles.
- HS→LS: the low phase runs from the end of the HS high phase to the next `ls_fall`, then at least one LS half-period.
- Guarantee: no `clkout` phase is ever shorter than min(`div_sel`+1, LS half-period − 1) cycles.
- Requirement: each LS half-period must be ≥ `SYNC_STAGES`+2 `hsclk_in` cycles.

## Configuration
- `CLKSW_RDY_EN` defined:
  - `rdy` is registered and equals (`hsclk_sel` == `hsclk_selected`) & (state != LS_WAIT).
  - `rdy` deasserts the cycle after `hsclk_sel` changes and reasserts the cycle after the new mode is selected.
- `CLKSW_RDY_EN` undefined: `rdy` is constant 1.

## Test plan
Common setup: `DIV_W`=4, `SYNC_STAGES`=2, `lsclk_in` period 16 `hsclk_in` cycles.
- Release reset with `hsclk_sel`=0:
  - `clkout` stays 0 until the first synced `lsclk_in` fall.
  - Then `clkout` tracks `lsclk_in` 3 cycles late (8 high/8 low), and `lsclk_selected`=1.
- Set `hsclk_sel`=1, `div_sel`=1:
  - At the next `ls_fall`, `hsclk_selected`=1 and `lsclk_selected`=0.
  - `clkout` runs 2 low/2 high, and `phase_end` pulses every 4 cycles.
- Change `div_sel` 1→3 in the first cycle of a high phase:
  - That phase still lasts 2 cycles.
  - All following phases last 4 cycles.
- Drop `hsclk_sel` to 0 in mid-low phase (`div_sel`=3):
  - The low phase and a full 4-cycle high phase complete, then `clkout` is held 0 until `ls_fall`, then tracks LS.
  - No phase is shorter than 4 cycles.
- Pulse `hsclk_sel` 1→0→1 so it is 1 again during LS_WAIT:
  - At `ls_fall` the state goes directly to HS_RUN.
  - `lsclk_selected` never asserts.
- `CLKSW_RDY_EN` defined:
  - `rdy` goes 0 one cycle after the `hsclk_sel` change and returns to 1 one cycle after the new mode is selected.
  - Assert `rst_b` during a high phase: `clkout` goes 0 asynchronously and `rdy`=0.
